stream_mac3_p: RTL and testbench

Parametrised streaming multiply-add unit, the next generation of the three-sample `a*b+c` block. It watches a valid-qualified input stream. After every run of three consecutive valid samples it produces `a*b+c` or `a*b-c` (a = oldest sample) one cycle later. Width, output truncation/saturation and window mode (sliding or non-overlapping) are parameters, and it reports overflow and a result count. It sits between the sample source and the downstream consumer and is checked by the team's SVA property module for this block family.

---
 rtl/stream_mac3_p.sv | 102 ++++++++++
 tb/tb_stream_mac3_p.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mac3_p.sv
// Streaming three-sample multiply-add: after each run of three consecutive valid
// samples (a oldest, c newest) it registers a*b+c or a*b-c with wrap or clamp.
module stream_mac3_p #(
    parameter int W     = 32,
    parameter int OW    = 32,
    parameter int SAT   = 0,
    parameter int SLIDE = 1,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          validi,
    input  logic [W-1:0]  data_in,
    input  logic          sub,
    output logic          valido,
    output logic [OW-1:0] data_out,
    output logic          ovf,
    output logic [CW-1:0] res_cnt
);

    localparam int XW = 2 * W + 2;

    logic [1:0]    run_reg, run_next;
    logic [W-1:0]  s1_reg, s2_reg;
    logic          valido_reg;
    logic [OW-1:0] data_out_reg;
    logic          ovf_reg;
    logic [CW-1:0] res_cnt_reg;

    logic          complete;
    logic [2*W-1:0] prod;
    logic [XW-1:0] exact;
    logic          neg;
    logic          out_of_range;
    logic [OW-1:0] result;

    assign complete = validi && (run_reg >= 2'd2);

    assign prod  = {{W{1'b0}}, s1_reg} * {{W{1'b0}}, s2_reg};
    assign exact = sub ? ({2'b00, prod} - {{(W+2){1'b0}}, data_in})
                       : ({2'b00, prod} + {{(W+2){1'b0}}, data_in});

    // Any set bit above the output range (sign included) means the exact
    // value does not fit in [0, 2^OW-1].
    assign neg          = exact[XW-1];
    assign out_of_range = |exact[XW-1:OW];

    generate
        if (SAT != 0) begin : g_sat
            always_comb begin
                if (neg)
                    result = '0;
                else if (out_of_range)
                    result = '1;
                else
                    result = exact[OW-1:0];
            end
        end else begin : g_wrap
            assign result = exact[OW-1:0];
        end
    endgenerate

    always_comb begin
        run_next = run_reg;
        if (!validi)
            run_next = 2'd0;
        else if ((SLIDE == 0) && complete)
            run_next = 2'd0;
        else if (run_reg != 2'd3)
            run_next = run_reg + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            run_reg      <= 2'd0;
            s1_reg       <= '0;
            s2_reg       <= '0;
            valido_reg   <= 1'b0;
            data_out_reg <= '0;
            ovf_reg      <= 1'b0;
            res_cnt_reg  <= '0;
        end else begin
            run_reg <= run_next;
            if (validi) begin
                s1_reg <= s2_reg;
                s2_reg <= data_in;
            end
            valido_reg <= complete;
            if (complete) begin
                data_out_reg <= result;
                ovf_reg      <= out_of_range;
                res_cnt_reg  <= res_cnt_reg + CW'(1);
            end
        end
    end

    assign valido   = valido_reg;
    assign data_out = data_out_reg;
    assign ovf      = ovf_reg;
    assign res_cnt  = res_cnt_reg;

endmodule

// File: tb/tb_stream_mac3_p.sv
// Bench for stream_mac3_p: directed scenarios plus a randomized run against a
// queue-based window model, on sliding, block and saturating instances.
module tb_stream_mac3_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_;
    logic       validi;
    logic       sub;
    logic [7:0] data_in;

    logic        v0, v1, v2, o0, o1, o2;
    logic [15:0] d0, d1;
    logic [11:0] d2;
    logic [7:0]  c0, c1;
    logic [2:0]  c2;

    int checks = 0;
    int errors = 0;

    stream_mac3_p #(.W(8), .OW(16), .SAT(0), .SLIDE(1), .CW(8)) u_slide (
        .clk(clk), .rst_(rst_), .validi(validi), .data_in(data_in), .sub(sub),
        .valido(v0), .data_out(d0), .ovf(o0), .res_cnt(c0));

    stream_mac3_p #(.W(8), .OW(16), .SAT(0), .SLIDE(0), .CW(8)) u_block (
        .clk(clk), .rst_(rst_), .validi(validi), .data_in(data_in), .sub(sub),
        .valido(v1), .data_out(d1), .ovf(o1), .res_cnt(c1));

    stream_mac3_p #(.W(8), .OW(12), .SAT(1), .SLIDE(1), .CW(3)) u_sat (
        .clk(clk), .rst_(rst_), .validi(validi), .data_in(data_in), .sub(sub),
        .valido(v2), .data_out(d2), .ovf(o2), .res_cnt(c2));

    logic        vout[3];
    logic        oout[3];
    logic [15:0] dout[3];
    logic [7:0]  cout[3];
    assign vout[0] = v0; assign vout[1] = v1; assign vout[2] = v2;
    assign oout[0] = o0; assign oout[1] = o1; assign oout[2] = o2;
    assign dout[0] = d0; assign dout[1] = d1; assign dout[2] = {4'b0, d2};
    assign cout[0] = c0; assign cout[1] = c1; assign cout[2] = {5'b0, c2};

    int q[3][$];

    task automatic step(input logic v, input logic [7:0] d, input logic s);
        validi  = v;
        data_in = d;
        sub     = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        validi = 1'b0; sub = 1'b0; data_in = '0;
        @(negedge clk); rst_ = 1'b0;
        @(negedge clk); rst_ = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            validi = 1'($urandom); data_in = 8'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (v0 !== 1'b0 || v1 !== 1'b0 || v2 !== 1'b0 || d0 !== 16'd0 || d1 !== 16'd0
                || d2 !== 12'd0 || c0 !== 8'd0 || c2 !== 3'd0)
                begin errors++; $display("FAIL reset_hold cyc %0d got v=%b%b%b d=%0d/%0d/%0d cnt=%0d want all 0", i, v0, v1, v2, d0, d1, d2, c0); end
        end
        @(negedge clk); rst_ = 1'b1; validi = 1'b0;
        @(posedge clk); #1;
        step(1, 1, 0); step(1, 2, 0); step(1, 3, 0);
        checks++;
        if (v0 !== 1'b1 || d0 !== 16'd5)
            begin errors++; $display("FAIL reset_pre got v=%b d=%0d want v=1 d=5", v0, d0); end
        #3 rst_ = 1'b0;
        #1;
        checks++;
        if (v0 !== 1'b0 || d0 !== 16'd0 || c0 !== 8'd0)
            begin errors++; $display("FAIL reset_async got v=%b d=%0d cnt=%0d want 0 0 0", v0, d0, c0); end
        @(negedge clk); rst_ = 1'b1; validi = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int dv[5], ev[5], ed[5];
        dv = '{3, 4, 5, 6, 0}; ev = '{0, 0, 1, 1, 0}; ed = '{0, 0, 17, 26, 26};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(i < 4, 8'(dv[i]), 0);
            checks++;
            if (v0 !== ev[i][0] || d0 !== 16'(ed[i]))
                begin errors++; $display("FAIL basic step %0d got v=%b d=%0d want v=%0d d=%0d", i, v0, d0, ev[i], ed[i]); end
        end
        checks++;
        if (c0 !== 8'd2) begin errors++; $display("FAIL basic_cnt got %0d want 2", c0); end
    endtask

    task automatic test_block();
        int ev[7], ed[7];
        ev = '{0, 0, 1, 0, 0, 1, 0}; ed = '{0, 0, 17, 17, 17, 50, 50};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(i < 6, 8'(i + 3), 0);
            checks++;
            if (v1 !== ev[i][0] || d1 !== 16'(ed[i]))
                begin errors++; $display("FAIL block step %0d got v=%b d=%0d want v=%0d d=%0d", i, v1, d1, ev[i], ed[i]); end
        end
        checks++;
        if (c1 !== 8'd2) begin errors++; $display("FAIL block_cnt got %0d want 2", c1); end
    endtask

    task automatic test_run_break();
        int vv[10];
        vv = '{1, 1, 0, 1, 1, 0, 1, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(vv[i][0], 8'(i + 1), 0);
            checks++;
            if (v0 !== (i == 8) || d0 !== ((i >= 8) ? 16'd65 : 16'd0))
                begin errors++; $display("FAIL run_break step %0d got v=%b d=%0d want v=%0d d=%0d", i, v0, d0, i == 8, (i >= 8) ? 65 : 0); end
        end
        checks++;
        if (c0 !== 8'd1) begin errors++; $display("FAIL run_break_cnt got %0d want 1", c0); end
    endtask

    task automatic test_sub_ovf();
        do_reset();
        step(1, 2, 0); step(1, 3, 0); step(1, 10, 1);
        checks++;
        if (v0 !== 1'b1 || d0 !== 16'hFFFC || o0 !== 1'b1)
            begin errors++; $display("FAIL sub_wrap got v=%b d=%h ovf=%b want 1 fffc 1", v0, d0, o0); end
        checks++;
        if (v2 !== 1'b1 || d2 !== 12'd0 || o2 !== 1'b1)
            begin errors++; $display("FAIL sub_sat got v=%b d=%h ovf=%b want 1 000 1", v2, d2, o2); end
        step(0, 0, 0);
        step(1, 255, 1); step(1, 255, 1); step(1, 255, 0);
        checks++;
        if (v0 !== 1'b1 || d0 !== 16'd65280 || o0 !== 1'b0)
            begin errors++; $display("FAIL max_wrap got v=%b d=%0d ovf=%b want 1 65280 0", v0, d0, o0); end
        checks++;
        if (v2 !== 1'b1 || d2 !== 12'hFFF || o2 !== 1'b1)
            begin errors++; $display("FAIL max_sat got v=%b d=%h ovf=%b want 1 fff 1", v2, d2, o2); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1, 3, 0); step(1, 4, 0);
        validi = 1'b0;
        #3 rst_ = 1'b0;
        @(negedge clk); rst_ = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            step(i < 3, 8'(i + 5), 0);
            checks++;
            if (v0 !== (i == 2) || d0 !== ((i >= 2) ? 16'd37 : 16'd0))
                begin errors++; $display("FAIL reset_mid step %0d got v=%b d=%0d want v=%0d d=%0d", i, v0, d0, i == 2, (i >= 2) ? 37 : 0); end
        end
        checks++;
        if (c0 !== 8'd1) begin errors++; $display("FAIL reset_mid_cnt got %0d want 1", c0); end
    endtask

    task automatic test_random();
        int     ow_k[3], slide_k[3], sat_k[3], cmask_k[3];
        logic   ev[3], eo[3];
        longint ed[3], ecnt[3];
        longint exact, mask;
        logic   v, s;
        logic [7:0] d;
        ow_k = '{16, 16, 12}; slide_k = '{1, 0, 1}; sat_k = '{0, 0, 1}; cmask_k = '{255, 255, 7};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            q[k].delete(); ev[k] = 0; eo[k] = 0; ed[k] = 0; ecnt[k] = 0;
        end
        for (int n = 0; n < 600; n++) begin
            v = ($urandom_range(0, 9) < 8);
            d = 8'($urandom);
            s = 1'($urandom);
            for (int k = 0; k < 3; k++) begin
                ev[k] = 1'b0;
                if (!v) begin
                    q[k].delete();
                end else begin
                    q[k].push_back(int'(d));
                    if (q[k].size() > 3) void'(q[k].pop_front());
                    if (q[k].size() == 3) begin
                        exact = longint'(q[k][0]) * longint'(q[k][1]);
                        exact = s ? exact - longint'(q[k][2]) : exact + longint'(q[k][2]);
                        mask  = (longint'(1) << ow_k[k]) - 1;
                        ev[k] = 1'b1;
                        eo[k] = (exact < 0) || (exact > mask);
                        if (sat_k[k] != 0)
                            ed[k] = (exact < 0) ? 0 : ((exact > mask) ? mask : exact);
                        else
                            ed[k] = exact & mask;
                        ecnt[k] = (ecnt[k] + 1) & longint'(cmask_k[k]);
                        if (slide_k[k] == 0) q[k].delete();
                    end
                end
            end
            step(v, d, s);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (vout[k] !== ev[k] || dout[k] !== 16'(ed[k]) || cout[k] !== 8'(ecnt[k]))
                    begin errors++; $display("FAIL random inst %0d cyc %0d got v=%b d=%0d cnt=%0d want v=%b d=%0d cnt=%0d", k, n, vout[k], dout[k], cout[k], ev[k], ed[k], ecnt[k]); end
                if (ev[k]) begin
                    checks++;
                    if (oout[k] !== eo[k])
                        begin errors++; $display("FAIL random_ovf inst %0d cyc %0d got %b want %b", k, n, oout[k], eo[k]); end
                end
            end
        end
    endtask

    initial begin
        rst_ = 1'b0; validi = 1'b0; sub = 1'b0; data_in = '0;
        test_reset();
        test_basic();
        test_block();
        test_run_break();
        test_sub_ovf();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
